// File: rtl/modmul_pkg.sv
// Shared modmul widths and the pipeline-valid record carried alongside datapath stages.
// Widths line up with k2red_m: A is 2W wide, Q is W wide.
package modmul_pkg;
    localparam int MM_W  = 64;
    localparam int MM_HW = MM_W / 2;
    localparam int MM_PW = 2 * MM_W;

    typedef struct packed {
        logic vld;
        logic err;
    } pv_t;
endpackage

// File: rtl/k2red_pp_mul.sv
// Registered HW x HW unsigned multiplier; p updates only when en is high.
// Latency 1 cycle; holds its product while en is low.
module k2red_pp_mul #(
    parameter int HW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [HW-1:0]   a,
    input  logic [HW-1:0]   b,
    output logic [2*HW-1:0] p
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p <= '0;
        end else if (en) begin
            p <= {{HW{1'b0}}, a} * {{HW{1'b0}}, b};
        end
    end
endmodule

// File: rtl/k2red_pp_mult.sv
// W x W -> 2W unsigned multiplier feeding K2-RED; four HW x HW partial products summed in S3.
// Latency 3 cycles, 1 product/cycle; per-stage bubble-collapsing stall, in_ready = en1.
// Optional range check on X/Y vs Q enabled by defining K2RED_RANGE_CHK_EN.
module k2red_pp_mult
    import modmul_pkg::*;
#(
    parameter int W = MM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     X,
    input  logic [W-1:0]     Y,
    input  logic [W-1:0]     Q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   A
`ifdef K2RED_RANGE_CHK_EN
    ,
    output logic             range_err
`endif
);
    localparam int HW = W / 2;
    localparam int PW = 2 * W;

    pv_t          s1, s2, s3;
    logic [W-1:0] x1, y1;
    logic         en1, en2, en3;
    logic         err_in;
    logic [W-1:0] p_ll, p_lh, p_hl, p_hh;
    logic [W:0]   mid;
    logic [PW-1:0] sum;

    assign en3      = ~s3.vld | out_ready;
    assign en2      = ~s2.vld | en3;
    assign en1      = ~s1.vld | en2;
    assign in_ready = en1;
    assign out_valid = s3.vld;

`ifdef K2RED_RANGE_CHK_EN
    assign err_in    = (X >= Q) | (Y >= Q);
    assign range_err = s3.err;
`else
    assign err_in = 1'b0;
    // Q stays on the pinout for compatibility; nothing consumes it in this build.
    logic unused_sig;
    assign unused_sig = ^{Q, s3.err};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            x1 <= '0;
            y1 <= '0;
        end else if (en1) begin
            s1.vld <= in_valid;
            s1.err <= err_in;
            x1     <= X;
            y1     <= Y;
        end
    end

    k2red_pp_mul #(.HW(HW)) u_ll (.clk(clk), .rst(rst), .en(en2), .a(x1[HW-1:0]), .b(y1[HW-1:0]), .p(p_ll));
    k2red_pp_mul #(.HW(HW)) u_lh (.clk(clk), .rst(rst), .en(en2), .a(x1[HW-1:0]), .b(y1[W-1:HW]),  .p(p_lh));
    k2red_pp_mul #(.HW(HW)) u_hl (.clk(clk), .rst(rst), .en(en2), .a(x1[W-1:HW]),  .b(y1[HW-1:0]), .p(p_hl));
    k2red_pp_mul #(.HW(HW)) u_hh (.clk(clk), .rst(rst), .en(en2), .a(x1[W-1:HW]),  .b(y1[W-1:HW]),  .p(p_hh));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2 <= '0;
        end else if (en2) begin
            s2 <= s1;
        end
    end

    // Cross terms summed at W+1 bits so the carry out of the middle column is kept.
    assign mid = {1'b0, p_lh} + {1'b0, p_hl};
    assign sum = {p_hh, {W{1'b0}}}
               + {{(HW-1){1'b0}}, mid, {HW{1'b0}}}
               + {{W{1'b0}}, p_ll};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3 <= '0;
            A  <= '0;
        end else if (en3) begin
            s3 <= s2;
            A  <= sum;
        end
    end
endmodule
